// File: rtl/rflp_fifo_ctrl_if.sv
// Push/pop handshake, occupancy and register-file macro command bus of the FIFO controller.
interface rflp_fifo_ctrl_if #(
  parameter int DW  = 26,
  parameter int RAW = 6,
  parameter int CAW = 2
);
  logic               IN_VALID;
  logic               IN_READY;
  logic [DW-1:0]      IN_DATA;
  logic               OUT_VALID;
  logic               OUT_READY;
  logic [DW-1:0]      OUT_DATA;
  logic [RAW+CAW:0]   COUNT;
  logic               MEM_NCE;
  logic               MEM_NWRT;
  logic [RAW-1:0]     MEM_RA;
  logic [CAW-1:0]     MEM_CA;
  logic [DW-1:0]      MEM_DIN;
  logic [DW-1:0]      MEM_DO;

  // controller side
  modport slave (
    input  IN_VALID, IN_DATA, OUT_READY, MEM_DO,
    output IN_READY, OUT_VALID, OUT_DATA, COUNT,
           MEM_NCE, MEM_NWRT, MEM_RA, MEM_CA, MEM_DIN
  );

  // producer / consumer / macro side
  modport master (
    output IN_VALID, IN_DATA, OUT_READY, MEM_DO,
    input  IN_READY, OUT_VALID, OUT_DATA, COUNT,
           MEM_NCE, MEM_NWRT, MEM_RA, MEM_CA, MEM_DIN
  );
endinterface

// File: rtl/rflp_fifo_ctrl.sv
// FIFO controller over a single-port 256x26 register-file macro.
// One macro op per cycle, round-robin write/read arbitration, 3-entry skid queue hiding read latency.
module rflp_fifo_ctrl #(
  parameter int DW   = 26,
  parameter int RAW  = 6,
  parameter int CAW  = 2,
  parameter int SKID = 3
) (
  input  logic           CLK,
  input  logic           RST,
  rflp_fifo_ctrl_if.slave bus
);
  localparam int AW   = RAW + CAW;
  localparam int SIW  = $clog2(SKID);
  localparam int SCW  = $clog2(SKID + 1);

  localparam logic [0:0] OP_RD = 1'b0;
  localparam logic [0:0] OP_WR = 1'b1;

  localparam logic [SIW-1:0] SK_LAST  = SIW'(SKID - 1);
  localparam logic [SCW+1:0] SK_LIMIT = (SCW + 2)'(SKID);

  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW:0]    count;
  logic [0:0]     last_op;
  logic           fl1;
  logic           fl2;

  logic           cmd_nce;
  logic           cmd_nwrt;
  logic [AW-1:0]  cmd_addr;
  logic [DW-1:0]  cmd_din;

  logic [DW-1:0]  sk_mem [SKID];
  logic [SIW-1:0] sk_head;
  logic [SIW-1:0] sk_tail;
  logic [SCW-1:0] sk_cnt;

  logic           pop;
  logic           push;
  logic [SCW+1:0] credit_use;
  logic           wreq;
  logic           rreq;
  logic           grant_wr;
  logic           grant_rd;

  assign pop  = (sk_cnt != '0) && bus.OUT_READY;
  assign push = fl2;

  // The head leaving this cycle frees its slot in time for a read issued now,
  // which is what allows one word per cycle on the pop side.
  assign credit_use = (SCW + 2)'(sk_cnt) + (SCW + 2)'(fl1) + (SCW + 2)'(fl2)
                    - (SCW + 2)'(pop);

  always_comb begin
    wreq     = 1'b0;
    rreq     = 1'b0;
    grant_wr = 1'b0;
    grant_rd = 1'b0;
    if (!RST) begin
      wreq = bus.IN_VALID && !count[AW];
      rreq = (count != '0) && (credit_use < SK_LIMIT);
      grant_wr = wreq && (!rreq || (last_op == OP_RD));
      grant_rd = rreq && (!wreq || (last_op == OP_WR));
    end
  end

  assign bus.IN_READY = grant_wr;

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      last_op  <= OP_RD;
      fl1      <= 1'b0;
      fl2      <= 1'b0;
      cmd_nce  <= 1'b1;
      cmd_nwrt <= 1'b1;
      cmd_addr <= '0;
      cmd_din  <= '0;
    end else begin
      cmd_nce  <= 1'b1;
      cmd_nwrt <= 1'b1;
      if (grant_wr) begin
        cmd_nce  <= 1'b0;
        cmd_nwrt <= 1'b0;
        cmd_addr <= wr_ptr;
        cmd_din  <= bus.IN_DATA;
        wr_ptr   <= wr_ptr + 1'b1;
        count    <= count + 1'b1;
        last_op  <= OP_WR;
      end else if (grant_rd) begin
        cmd_nce  <= 1'b0;
        cmd_addr <= rd_ptr;
        rd_ptr   <= rd_ptr + 1'b1;
        count    <= count - 1'b1;
        last_op  <= OP_RD;
      end
      // fl1: command issued, fl2: macro sampled it, MEM_DO valid for capture
      fl1 <= grant_rd;
      fl2 <= fl1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < SKID; i++) sk_mem[i] <= '0;
      sk_head <= '0;
      sk_tail <= '0;
      sk_cnt  <= '0;
    end else begin
      if (push) begin
        sk_mem[sk_tail] <= bus.MEM_DO;
        sk_tail <= (sk_tail == SK_LAST) ? '0 : sk_tail + 1'b1;
      end
      if (pop) begin
        sk_head <= (sk_head == SK_LAST) ? '0 : sk_head + 1'b1;
      end
      sk_cnt <= sk_cnt + SCW'(push) - SCW'(pop);
    end
  end

  assign bus.OUT_VALID = (sk_cnt != '0);
  assign bus.OUT_DATA  = sk_mem[sk_head];
  assign bus.COUNT     = count;
  assign bus.MEM_NCE   = cmd_nce;
  assign bus.MEM_NWRT  = cmd_nwrt;
  assign bus.MEM_RA    = cmd_addr[AW-1:CAW];
  assign bus.MEM_CA    = cmd_addr[CAW-1:0];
  assign bus.MEM_DIN   = cmd_din;
endmodule

// File: tb/tb_rflp_fifo_ctrl.sv
// Bench for rflp_fifo_ctrl with a behavioural register-file macro and a queue scoreboard.
module tb_rflp_fifo_ctrl;
  localparam int DW  = 26;
  localparam int RAW = 6;
  localparam int CAW = 2;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  rflp_fifo_ctrl_if #(.DW(DW), .RAW(RAW), .CAW(CAW)) bus ();
  rflp_fifo_ctrl #(.DW(DW), .RAW(RAW), .CAW(CAW), .SKID(3)) dut (
    .CLK(CLK), .RST(RST), .bus(bus)
  );

  // macro: samples command on rising edge, DO updates just after a read sample
  logic [DW-1:0] mem [256];
  logic [DW-1:0] do_q = '0;
  always @(posedge CLK) begin
    if (!bus.MEM_NCE) begin
      if (!bus.MEM_NWRT) mem[{bus.MEM_RA, bus.MEM_CA}] <= bus.MEM_DIN;
      else do_q <= mem[{bus.MEM_RA, bus.MEM_CA}];
    end
  end
  assign bus.MEM_DO = do_q;

  int n_cmp = 0;
  int n_bad = 0;
  logic [DW-1:0] sb [$];
  bit took_in, took_out;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input bit iv, input logic [DW-1:0] d, input bit ordy);
    bus.IN_VALID  = iv;
    bus.IN_DATA   = d;
    bus.OUT_READY = ordy;
    #1;
  endtask

  // scoreboard bookkeeping for the current cycle, then advance to next negedge
  task automatic finish_cycle();
    int res;
    took_in  = bus.IN_VALID && bus.IN_READY;
    took_out = bus.OUT_VALID && bus.OUT_READY;
    if (!RST) begin
      res = sb.size() - int'(bus.COUNT);
      chk("count_range", (bus.COUNT <= 9'd256), 1);
      chk("resident_bound", (res >= 0 && res <= 3), 1);
    end
    if (took_out) begin
      if (sb.size() == 0) chk("pop_underflow", 1, 0);
      else chk("pop_data", bus.OUT_DATA, sb.pop_front());
    end
    if (took_in) sb.push_back(bus.IN_DATA);
    @(negedge CLK);
  endtask

  task automatic cycle(input bit iv, input logic [DW-1:0] d, input bit ordy);
    drive(iv, d, ordy);
    finish_cycle();
  endtask

  task automatic drain(input string nm);
    int c;
    for (c = 0; c < 2000 && sb.size() != 0; c++) cycle(0, '0, 1);
    chk({nm, "_drained"}, sb.size(), 0);
    drive(0, '0, 1);
    chk({nm, "_count0"}, bus.COUNT, 0);
    chk({nm, "_ov0"}, bus.OUT_VALID, 0);
    finish_cycle();
  endtask

  typedef struct {
    bit            iv;
    logic [DW-1:0] d;
    bit            ordy;
    bit            e_ir;
    bit            e_ov;
    bit            chk_od;
    logic [DW-1:0] e_od;
    logic [8:0]    e_cnt;
    bit            e_nce;
    bit            e_nwrt;
  } vec_t;

  vec_t tv [14];

  initial begin
    logic [DW-1:0] v;
    int acc, gap, pops, c;
    bit prev_nwrt, seen_pop;

    //       iv  data        ordy ir ov chkod od           cnt nce nwrt
    tv[0]  = '{1, 26'h2ABCDE, 1,  1, 0, 0, '0,           0,  1,  1};
    tv[1]  = '{0, '0,         1,  0, 0, 0, '0,           1,  0,  0};
    tv[2]  = '{0, '0,         1,  0, 0, 0, '0,           0,  0,  1};
    tv[3]  = '{0, '0,         1,  0, 0, 0, '0,           0,  1,  1};
    tv[4]  = '{0, '0,         1,  0, 1, 1, 26'h2ABCDE,   0,  1,  1};
    tv[5]  = '{0, '0,         1,  0, 0, 0, '0,           0,  1,  1};
    tv[6]  = '{1, 26'h0000A1, 0,  1, 0, 0, '0,           0,  1,  1};
    tv[7]  = '{1, 26'h0000B2, 0,  0, 0, 0, '0,           1,  0,  0};
    tv[8]  = '{1, 26'h0000B2, 0,  1, 0, 0, '0,           0,  0,  1};
    tv[9]  = '{0, '0,         0,  0, 0, 0, '0,           1,  0,  0};
    tv[10] = '{0, '0,         0,  0, 1, 1, 26'h0000A1,   0,  0,  1};
    tv[11] = '{0, '0,         1,  0, 1, 1, 26'h0000A1,   0,  1,  1};
    tv[12] = '{0, '0,         1,  0, 1, 1, 26'h0000B2,   0,  1,  1};
    tv[13] = '{0, '0,         1,  0, 0, 0, '0,           0,  1,  1};

    // reset with a pending producer
    bus.IN_VALID = 1; bus.IN_DATA = '0; bus.OUT_READY = 0;
    @(posedge CLK); @(negedge CLK);
    for (int i = 0; i < 2; i++) begin
      drive(1, 26'h3, 0);
      chk("rst_in_ready", bus.IN_READY, 0);
      chk("rst_nce", bus.MEM_NCE, 1);
      chk("rst_nwrt", bus.MEM_NWRT, 1);
      chk("rst_ov", bus.OUT_VALID, 0);
      chk("rst_count", bus.COUNT, 0);
      chk("rst_addr", {bus.MEM_RA, bus.MEM_CA}, 0);
      @(negedge CLK);
    end
    RST = 0;

    // directed vectors: single word latency and write/read tie-break
    for (int i = 0; i < 14; i++) begin
      drive(tv[i].iv, tv[i].d, tv[i].ordy);
      chk($sformatf("vec%0d_in_ready", i), bus.IN_READY, tv[i].e_ir);
      chk($sformatf("vec%0d_out_valid", i), bus.OUT_VALID, tv[i].e_ov);
      if (tv[i].chk_od) chk($sformatf("vec%0d_out_data", i), bus.OUT_DATA, tv[i].e_od);
      chk($sformatf("vec%0d_count", i), bus.COUNT, tv[i].e_cnt);
      chk($sformatf("vec%0d_nce", i), bus.MEM_NCE, tv[i].e_nce);
      chk($sformatf("vec%0d_nwrt", i), bus.MEM_NWRT, tv[i].e_nwrt);
      finish_cycle();
    end

    // fill to 259 with consumer stalled, drain, twice so the pointers wrap
    v = '0;
    for (int rep = 0; rep < 2; rep++) begin
      acc = 0;
      for (c = 0; c < 700; c++) begin
        cycle(1, v, 0);
        if (took_in) begin v++; acc++; end
      end
      chk("fill_accepted", acc, 259);
      drive(1, v, 0);
      chk("fill_in_ready", bus.IN_READY, 0);
      chk("fill_count", bus.COUNT, 256);
      chk("fill_ov", bus.OUT_VALID, 1);
      chk("fill_skid_full", sb.size() - int'(bus.COUNT), 3);
      finish_cycle();
      drain("fill");
    end

    // streaming: alternating macro ops, one pop every other cycle at most
    gap = 0; pops = 0; seen_pop = 0; prev_nwrt = 1;
    for (c = 0; c < 200; c++) begin
      drive(1, v, 1);
      if (c >= 6) begin
        chk("stream_nce", bus.MEM_NCE, 0);
        chk("stream_alt", bus.MEM_NWRT != prev_nwrt, 1);
        chk("stream_count", bus.COUNT <= 9'd2, 1);
      end
      prev_nwrt = bus.MEM_NWRT;
      finish_cycle();
      if (took_in) v++;
      if (took_out) begin pops++; seen_pop = 1; gap = 0; end
      else if (seen_pop) begin
        gap++;
        chk("stream_gap", gap <= 1, 1);
      end
    end
    chk("stream_pops", pops >= 95, 1);
    drain("stream");

    // random producer/consumer against the scoreboard
    acc = 0;
    for (c = 0; c < 30000 && acc < 2000; c++) begin
      cycle($urandom_range(0, 9) < 6, DW'($urandom), $urandom_range(0, 1) == 1);
      if (took_in) acc++;
    end
    chk("rand_accepted", acc, 2000);
    drain("rand");

    // reset while reads are in flight
    acc = 0;
    for (c = 0; c < 100 && acc < 20; c++) begin
      cycle(1, DW'(26'h100 + acc), 0);
      if (took_in) acc++;
    end
    chk("mid_setup", acc, 20);
    for (c = 0; c < 200; c++) begin
      drive(0, '0, 1);
      if (bus.COUNT == 9'd10) break;
      finish_cycle();
    end
    chk("mid_reach10", bus.COUNT, 10);
    RST = 1;
    sb.delete();
    @(negedge CLK);
    cycle(0, '0, 1);
    RST = 0;
    for (int i = 0; i < 5; i++) begin
      drive(0, '0, 1);
      chk("mid_ov0", bus.OUT_VALID, 0);
      chk("mid_count0", bus.COUNT, 0);
      finish_cycle();
    end
    cycle(1, 26'h155555, 1);
    chk("mid_push_taken", took_in, 1);
    for (c = 0; c < 10; c++) begin
      drive(0, '0, 1);
      if (bus.OUT_VALID) break;
      finish_cycle();
    end
    chk("mid_first_valid", bus.OUT_VALID, 1);
    chk("mid_first_data", bus.OUT_DATA, 26'h155555);
    finish_cycle();
    drain("mid");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/rflp_fifo_ctrl.md
# rflp_fifo_ctrl

Synchronous FIFO controller that uses the single-port 256x26 register-file macro as its storage array. It sits directly upstream of the macro, driving NCE/NWRT/RA/CA/DIN and consuming DO. It presents a valid/ready push port to the producer and a valid/ready pop port to the consumer. A 3-entry output skid queue hides the macro's read latency.

## Interface
- DW, 26, data width (matches macro DIN/DO)
- RAW, 6, macro row-address width
- CAW, 2, macro column-address width; depth = 2^(RAW+CAW) = 256
- SKID, 3, output skid-queue depth
- CLK  in  1  rising-edge clock, shared with the macro
- RST  in  1  synchronous, active-high reset
- IN_VALID  in  1  producer has a word
- IN_READY  out  1  controller accepts IN_DATA this cycle
- IN_DATA  in  DW  push data
- OUT_VALID  out  1  OUT_DATA holds the head word
- OUT_READY  in  1  consumer takes the head word
- OUT_DATA  out  DW  head of skid queue
- COUNT  out  RAW+CAW+1  words resident in the macro, range 0..256
- MEM_NCE  out  1  macro chip enable, active low, registered
- MEM_NWRT  out  1  macro write enable, active low, registered
- MEM_RA  out  RAW  macro row address, registered
- MEM_CA  out  CAW  macro column address, registered
- MEM_DIN  out  DW  macro write data, registered
- MEM_DO  in  DW  macro read data

## Operation
- Pointers: wr_ptr and rd_ptr are 8 bits each. Address mapping is {MEM_RA, MEM_CA} = ptr (RA = ptr[7:2], CA = ptr[1:0]). Pointers wrap 255 -> 0 naturally.
- Write request (wreq) = IN_VALID && COUNT < 256.
- Read request (rreq) = COUNT > 0 && (skid occupancy + reads in flight) < SKID.
- Arbiter: at most one macro operation per cycle.
  - Only wreq: grant write.
  - Only rreq: grant read.
  - Both: round-robin on a last_op flag (grant the opposite of the last granted op).
  - Neither: idle (MEM_NCE=1, MEM_NWRT=1, address and DIN hold their values).
- IN_READY = write granted this cycle. It is combinational from IN_VALID, COUNT and last_op.
- On a write grant at edge k:
  - Command flops load NCE=0, NWRT=0, RA/CA = wr_ptr, DIN = IN_DATA.
  - wr_ptr and COUNT increment.
- On a read grant at edge k:
  - Command flops load NCE=0, NWRT=1, RA/CA = rd_ptr.
  - rd_ptr increments and COUNT decrements.
  - A 2-stage in-flight valid pipe is marked.
- Read pipeline: the macro samples the command at edge k+1 and MEM_DO is valid shortly after. The skid queue captures MEM_DO at edge k+2, using the in-flight pipe's stage-2 valid.
- Skid queue:
  - 3-entry FIFO; OUT_DATA/OUT_VALID reflect its head.
  - Pop on OUT_VALID && OUT_READY.
  - A push and a pop may occur on the same edge.
  - The credit check guarantees the queue never overflows.
- COUNT changes on the grant edge, not the macro edge. A write commits at edge k+1, so any read of that address reaches the macro at edge k+2 or later. Read-after-write ordering is therefore guaranteed.
- Total buffering is 259 words (256 in the macro + 3 in the skid queue).

## Timing
- Reset values (while RST is high and after its release edge):
  - MEM_NCE=1, MEM_NWRT=1, MEM_RA=0, MEM_CA=0, MEM_DIN=0.
  - Pointers=0, COUNT=0, last_op=read (so a write wins the first tie).
  - In-flight pipe cleared, skid empty, OUT_VALID=0, OUT_DATA=0.
  - IN_READY=0 while RST=1.
- Reset mid-operation: in-flight reads are discarded, because MEM_DO arriving after reset is not captured. Macro contents are not cleared.
- Push-to-pop latency: a word accepted at edge k gives OUT_VALID=1 after edge k+3 when the queue was empty.
- Pop throughput with OUT_READY=1 and no writes: 1 word/cycle.
- Sustained streaming (IN_VALID=1, OUT_READY=1): 1 word per 2 cycles, because writes and reads alternate.
- Full: COUNT=256 forces IN_READY=0 until a read grant. Empty: COUNT=0 and skid empty give OUT_VALID=0.
- Command outputs change only on rising CLK, one cycle ahead of macro sampling. This satisfies the macro's 0.6 ns address setup at a 3 ns clock.

## Test plan
- Reset: RST=1 for 2 cycles with IN_VALID=1 -> IN_READY=0, MEM_NCE=1, MEM_NWRT=1, OUT_VALID=0, COUNT=0; then IN_READY=1 on the first cycle after release.
- Single word: push 26'h2ABCDE at edge k into an empty FIFO with OUT_READY=1 -> OUT_VALID=1 and OUT_DATA=26'h2ABCDE after edge k+3, COUNT back to 0.
- Fill and wrap: with OUT_READY=0, push values 0..258 -> exactly 259 accepted, then IN_READY=0, COUNT=256, skid full. Then pop all with OUT_READY=1 -> values 0..258 in order. Repeat once so the pointers wrap past 255 -> 0 with no corruption.
- Streaming: IN_VALID=1 and OUT_READY=1 for 200 cycles with an incrementing pattern -> writes and reads alternate on MEM_NWRT, output stays in order with no gaps beyond 1 idle cycle in 2, and COUNT stays ≤ 2.
- Backpressure: random OUT_READY (50%) and random IN_VALID over 2000 words -> scoreboard exact match, no drop or duplicate, skid never exceeds 3.
- Reset mid-stream: assert RST while 2 reads are in flight and COUNT=10 -> after release OUT_VALID=0 and COUNT=0. The next push 26'h155555 is popped as the first word.
